// File: rtl/dog_scheduler.sv
// dog_scheduler
// Walks the single dog datapath across every adjacent pair of blurred scale
// images (k, k+1) and produces NUM_SCALES-1 difference banks. For each pair it
// selects the source scales and the output bank, launches dog and waits for it
// to finish. When SEND_EACH is set, it also hands the finished bank to send_img.
//
// Ports:
//   clk, rst_in        system clock, asynchronous active-high reset
//   start              pulse: all scales loaded, begin a full run (IDLE only)
//   dog_busy, tx_busy  busy flags from dog / send_img
//   dog_start          one-cycle launch pulse to dog (bram_ready)
//   tx_start           one-cycle launch pulse to send_img (img_ready)
//   sharper_sel        scale index for dog sharper_pix
//   fuzzier_sel        scale index for dog fuzzier_pix (sharper_sel+1)
//   out_bank           DoG output bank (current pair index)
//   out_we_en          output BRAM write gate, high only in RUN
//   busy               high whenever not IDLE
//   done               one-cycle pulse after the last pair completes
//   error              sticky handshake-timeout flag
//
// State table
//   IDLE        | waiting for start
//   LAUNCH      | dog_start pulse, clear ack timer
//   WAIT_ACK    | waiting for dog_busy to rise (timed)
//   RUN         | dog running, output writes enabled
//   SEND        | tx_start pulse, clear ack timer
//   WAIT_TX_ACK | waiting for tx_busy to rise (timed)
//   WAIT_TX     | waiting for send_img to finish
//   NEXT        | advance pair, or finish the run
//   ERROR       | handshake timeout, held until reset

module dog_scheduler #(
  parameter int NUM_SCALES  = 5,
  parameter int ACK_TIMEOUT = 16,
  parameter int SEND_EACH   = 1,
  localparam int SEL_W      = $clog2(NUM_SCALES)
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             start,
  input  logic             dog_busy,
  input  logic             tx_busy,
  output logic             dog_start,
  output logic             tx_start,
  output logic [SEL_W-1:0] sharper_sel,
  output logic [SEL_W-1:0] fuzzier_sel,
  output logic [SEL_W-1:0] out_bank,
  output logic             out_we_en,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [SEL_W-1:0] LAST_PAIR = SEL_W'(NUM_SCALES - 2);
  localparam logic [TW-1:0]    TIMER_END = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, LAUNCH, WAIT_ACK, RUN, SEND, WAIT_TX_ACK, WAIT_TX, NEXT, ERROR
  } state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] pair, pair_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic             error_nxt;

  always_comb begin
    state_nxt = state;
    pair_nxt  = pair;
    timer_nxt = timer;
    error_nxt = error;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LAUNCH;
          pair_nxt  = '0;
          error_nxt = 1'b0;
        end
      end
      LAUNCH: begin
        timer_nxt = '0;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (dog_busy) begin
          state_nxt = RUN;
        end else if (timer == TIMER_END) begin
          state_nxt = ERROR;
          error_nxt = 1'b1;
        end else if (timer != '1) begin
          timer_nxt = timer + TW'(1);
        end
      end
      RUN: begin
        if (!dog_busy) state_nxt = (SEND_EACH != 0) ? SEND : NEXT;
      end
      SEND: begin
        timer_nxt = '0;
        state_nxt = WAIT_TX_ACK;
      end
      WAIT_TX_ACK: begin
        if (tx_busy) begin
          state_nxt = WAIT_TX;
        end else if (timer == TIMER_END) begin
          state_nxt = ERROR;
          error_nxt = 1'b1;
        end else if (timer != '1) begin
          timer_nxt = timer + TW'(1);
        end
      end
      WAIT_TX: begin
        if (!tx_busy) state_nxt = NEXT;
      end
      NEXT: begin
        if (pair == LAST_PAIR) begin
          state_nxt = IDLE;
        end else begin
          pair_nxt  = pair + SEL_W'(1);
          state_nxt = LAUNCH;
        end
      end
      ERROR: state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so each one is valid
  // for exactly the cycle the FSM spends in the matching state. Selects only
  // move when pair advances, which happens on NEXT->LAUNCH.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      pair        <= '0;
      timer       <= '0;
      dog_start   <= 1'b0;
      tx_start    <= 1'b0;
      sharper_sel <= '0;
      fuzzier_sel <= SEL_W'(1);
      out_bank    <= '0;
      out_we_en   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pair        <= pair_nxt;
      timer       <= timer_nxt;
      dog_start   <= (state_nxt == LAUNCH);
      tx_start    <= (state_nxt == SEND);
      sharper_sel <= pair_nxt;
      fuzzier_sel <= pair_nxt + SEL_W'(1);
      out_bank    <= pair_nxt;
      out_we_en   <= (state_nxt == RUN);
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == NEXT) && (pair_nxt == LAST_PAIR);
      error       <= error_nxt;
    end
  end

endmodule

// File: tb/tb_dog_scheduler.sv
// Testbench for dog_scheduler: three instances cover the 3-scale no-send,
// 3-scale send and 2-scale send configurations, each driven by behavioural
// dog/send_img busy models.

module tb_dog_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, start, dog_busy, tx_busy;
  logic [2:0] ds, ts, we, bz, dn, er;
  logic [1:0] ss0, fs0, ob0, ss1, fs1, ob1;
  logic [0:0] ss2, fs2, ob2;

  logic [2:0] man_en, man_val, mdl_db, mdl_tb;
  int dly[3], dhold[3], thold[3];

  assign dog_busy = (man_en & man_val) | (~man_en & mdl_db);
  assign tx_busy  = mdl_tb;

  dog_scheduler #(.NUM_SCALES(3), .ACK_TIMEOUT(8), .SEND_EACH(0)) u0 (
    .clk(clk), .rst_in(rst[0]), .start(start[0]), .dog_busy(dog_busy[0]),
    .tx_busy(tx_busy[0]), .dog_start(ds[0]), .tx_start(ts[0]),
    .sharper_sel(ss0), .fuzzier_sel(fs0), .out_bank(ob0), .out_we_en(we[0]),
    .busy(bz[0]), .done(dn[0]), .error(er[0]));

  dog_scheduler #(.NUM_SCALES(3), .ACK_TIMEOUT(8), .SEND_EACH(1)) u1 (
    .clk(clk), .rst_in(rst[1]), .start(start[1]), .dog_busy(dog_busy[1]),
    .tx_busy(tx_busy[1]), .dog_start(ds[1]), .tx_start(ts[1]),
    .sharper_sel(ss1), .fuzzier_sel(fs1), .out_bank(ob1), .out_we_en(we[1]),
    .busy(bz[1]), .done(dn[1]), .error(er[1]));

  dog_scheduler #(.NUM_SCALES(2), .ACK_TIMEOUT(8), .SEND_EACH(1)) u2 (
    .clk(clk), .rst_in(rst[2]), .start(start[2]), .dog_busy(dog_busy[2]),
    .tx_busy(tx_busy[2]), .dog_start(ds[2]), .tx_start(ts[2]),
    .sharper_sel(ss2), .fuzzier_sel(fs2), .out_bank(ob2), .out_we_en(we[2]),
    .busy(bz[2]), .done(dn[2]), .error(er[2]));

  // dog: busy rises 2 cycles after dog_start and stays high 20 cycles.
  // send_img: busy rises the cycle after tx_start and stays high 10 cycles.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        mdl_db[i] <= 1'b0;
        mdl_tb[i] <= 1'b0;
        dly[i]    <= 0;
        dhold[i]  <= 0;
        thold[i]  <= 0;
      end else begin
        if (ds[i]) begin
          dly[i] <= 1;
        end else if (dly[i] == 1) begin
          dly[i]    <= 0;
          mdl_db[i] <= 1'b1;
          dhold[i]  <= 19;
        end else if (mdl_db[i]) begin
          if (dhold[i] > 0) dhold[i] <= dhold[i] - 1;
          else mdl_db[i] <= 1'b0;
        end
        if (ts[i]) begin
          mdl_tb[i] <= 1'b1;
          thold[i]  <= 9;
        end else if (mdl_tb[i]) begin
          if (thold[i] > 0) thold[i] <= thold[i] - 1;
          else mdl_tb[i] <= 1'b0;
        end
      end
    end
  end

  // Observation of the instance under test
  int   act;
  logic m_ds, m_ts, m_we, m_bz, m_dn, m_er, m_db, m_tb;
  int   m_ss, m_fs, m_ob;

  always_comb begin
    m_ds = ds[act]; m_ts = ts[act]; m_we = we[act]; m_bz = bz[act];
    m_dn = dn[act]; m_er = er[act]; m_db = dog_busy[act]; m_tb = tx_busy[act];
    m_ss = 0; m_fs = 0; m_ob = 0;
    case (act)
      0: begin m_ss = int'(ss0); m_fs = int'(fs0); m_ob = int'(ob0); end
      1: begin m_ss = int'(ss1); m_fs = int'(fs1); m_ob = int'(ob1); end
      default: begin m_ss = int'(ss2); m_fs = int'(fs2); m_ob = int'(ob2); end
    endcase
  end

  int   log_q[$];
  int   exp_q[$];
  int   cyc, we_cnt, overlap, we_bad, max_ss, fall_cyc, done_cyc;
  logic p_db, p_tb;

  // Event codes: dog_start 1000+sharper*100+fuzzier*10+bank, tx_start
  // 2000+bank, done 3000.
  always @(negedge clk) begin
    cyc++;
    if (m_ds) log_q.push_back(1000 + m_ss * 100 + m_fs * 10 + m_ob);
    if (m_ts) log_q.push_back(2000 + m_ob);
    if (m_dn) begin
      log_q.push_back(3000);
      done_cyc = cyc;
    end
    if (m_ds && m_ts) overlap++;
    if (m_we) we_cnt++;
    if (m_we && !m_db && !p_db) we_bad++;
    if ((p_db && !m_db) || (p_tb && !m_tb)) fall_cyc = cyc;
    if (m_bz && m_ss > max_ss) max_ss = m_ss;
    p_db = m_db;
    p_tb = m_tb;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int got, input int expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic clear_mon();
    log_q.delete();
    we_cnt = 0; overlap = 0; we_bad = 0; max_ss = 0;
    fall_cyc = 0; done_cyc = 0;
  endtask

  task automatic check_log(input string tag);
    check_val({tag, "_len"}, log_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++)
      check_val({tag, "_ev"}, log_q[k], exp_q[k]);
  endtask

  // Leaves the caller #1 into the cycle after start was sampled (LAUNCH).
  task automatic pulse_start(input int i);
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
  endtask

  // Waits for done, checks busy is still high with it and drops next cycle.
  task automatic finish_run(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(posedge clk); #1;
      if (m_dn) seen = 1'b1;
    end
    check_val({tag, "_done_seen"}, int'(seen), 1);
    check_val({tag, "_busy_at_done"}, int'(m_bz), 1);
    @(posedge clk); #1;
    check_val({tag, "_busy_after"}, int'(m_bz), 0);
    check_val({tag, "_done_one"}, int'(m_dn), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    rst = 3'b111; start = '0; man_en = '0; man_val = '0; act = 0;
    p_db = 1'b0; p_tb = 1'b0; cyc = 0;
    clear_mon();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      check_val("rst_ctrl", int'({ds[i], ts[i], we[i], bz[i], dn[i], er[i]}), 0);
    check_val("rst_sel0", int'({ss0, ob0}), 0);
    check_val("rst_fz0", int'(fs0), 1);
    check_val("rst_fz1", int'(fs1), 1);
    check_val("rst_fz2", int'(fs2), 1);
    rst = 3'b000;
    repeat (2) @(posedge clk);

    // 3 scales, no send
    act = 0; clear_mon();
    pulse_start(0);
    check_val("t1_latency", int'(m_ds), 1);
    check_val("t1_sel", m_ss * 100 + m_fs * 10 + m_ob, 10);
    finish_run("t1");
    check_val("t1_done_lat", done_cyc - fall_cyc, 1);
    exp_q = '{1010, 1121, 3000};
    check_log("t1_log");
    check_val("t1_we_cnt", we_cnt, 40);
    check_val("t1_we_bad", we_bad, 0);

    // 3 scales, send each bank
    repeat (3) @(posedge clk);
    act = 1; clear_mon();
    pulse_start(1);
    check_val("t2_latency", int'(m_ds), 1);
    finish_run("t2");
    check_val("t2_done_lat", done_cyc - fall_cyc, 1);
    exp_q = '{1010, 2000, 1121, 2001, 3000};
    check_log("t2_log");
    check_val("t2_overlap", overlap, 0);
    check_val("t2_we_cnt", we_cnt, 40);
    check_val("t2_we_bad", we_bad, 0);

    // Ack timeout: dog never raises busy
    repeat (3) @(posedge clk);
    act = 0; clear_mon();
    man_en[0] = 1'b1; man_val[0] = 1'b0;
    pulse_start(0);
    check_val("t3_launch", int'(m_ds), 1);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 8) check_val("t3_err_early", int'(m_er), 0);
      if (k == 9) check_val("t3_err_set", int'(m_er), 1);
    end
    pulse_start(0);
    repeat (20) @(posedge clk);
    #1;
    check_val("t3_no_pulses", log_q.size(), 1);
    check_val("t3_err_hold", int'(m_er), 1);
    check_val("t3_busy_hold", int'(m_bz), 1);
    @(negedge clk); #1 rst[0] = 1'b1;
    #1;
    check_val("t3_rst_err", int'(m_er), 0);
    check_val("t3_rst_busy", int'(m_bz), 0);
    @(posedge clk); #1 rst[0] = 1'b0; man_en[0] = 1'b0;
    @(posedge clk); #1;
    check_val("t3_idle", int'(m_bz), 0);

    // Asynchronous reset in the middle of pair 1
    clear_mon();
    pulse_start(0);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk); #1;
      if (m_ss == 1 && m_we) found = 1'b1;
    end
    check_val("t4_reach_run1", int'(found), 1);
    @(negedge clk); #1 rst[0] = 1'b1;
    #1;
    check_val("t4_rst_ctrl", int'({m_ds, m_ts, m_we, m_bz, m_dn, m_er}), 0);
    check_val("t4_rst_sel", m_ss * 10 + m_ob, 0);
    check_val("t4_rst_fz", m_fs, 1);
    @(posedge clk); #1 rst[0] = 1'b0;
    repeat (2) @(posedge clk);
    clear_mon();
    pulse_start(0);
    check_val("t4_restart_sel", m_ss * 100 + m_fs * 10 + m_ob, 10);
    finish_run("t4");
    exp_q = '{1010, 1121, 3000};
    check_log("t4_log");

    // Immediate ack and a start pulse ignored during RUN
    repeat (3) @(posedge clk);
    clear_mon();
    man_en[0] = 1'b1; man_val[0] = 1'b1;
    pulse_start(0);
    check_val("t5_launch", int'(m_ds), 1);
    @(posedge clk); #1;
    check_val("t5_wait_ack_we", int'(m_we), 0);
    @(posedge clk); #1;
    check_val("t5_run_we", int'(m_we), 1);
    pulse_start(0);
    repeat (3) @(posedge clk);
    #1 man_en[0] = 1'b0;
    finish_run("t5");
    repeat (30) @(posedge clk);
    exp_q = '{1010, 1121, 3000};
    check_log("t5_log");

    // Single pair with send
    act = 2; clear_mon();
    pulse_start(2);
    check_val("t6_latency", int'(m_ds), 1);
    finish_run("t6");
    exp_q = '{1010, 2000, 3000};
    check_log("t6_log");
    check_val("t6_max_pair", max_ss, 0);
    check_val("t6_overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dog_scheduler.md
Name: dog_scheduler

Overview:
- Sequences the single `dog` datapath across every adjacent pair of Gaussian-blurred scale images, producing NUM_SCALES-1 difference images.
- For each pair it:
  - selects the source BRAMs (sharper = scale k, fuzzier = scale k+1) and the output bank,
  - launches `dog`, then waits for completion,
  - optionally hands the finished bank to `send_img` before moving to the next pair.
- Sits between the image-receive/blur BRAM banks and the `dog` / `send_img` instances in the top level, replacing the manual button sequencing.

Parameters:
- NUM_SCALES, 5, number of blurred scale images; must be ≥2; pairs = NUM_SCALES-1.
- ACK_TIMEOUT, 16, max cycles allowed between a start pulse and the corresponding busy rising; must be ≥2.
- SEND_EACH, 1, 1 = transmit each DoG bank via `send_img` after it completes; 0 = skip transmission.

Ports:
- clk  in  1  system clock.
- rst_in  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse: all scale images loaded; begin a full run.
- dog_busy  in  1  busy output of `dog`.
- tx_busy  in  1  busy output of `send_img`.
- dog_start  out  1  single-cycle pulse to `dog` bram_ready.
- tx_start  out  1  single-cycle pulse to `send_img` img_ready.
- sharper_sel  out  $clog2(NUM_SCALES)  scale index muxed onto `dog` sharper_pix.
- fuzzier_sel  out  $clog2(NUM_SCALES)  scale index muxed onto `dog` fuzzier_pix; always sharper_sel+1.
- out_bank  out  $clog2(NUM_SCALES)  DoG output bank written/read; equals current pair index.
- out_we_en  out  1  gates the output-BRAM write enable; high only in RUN.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  single-cycle pulse when the last pair (and its send) completes.
- error  out  1  sticky flag: handshake timeout.

Behaviour:
- Reset (asynchronous, any state, mid-run included): state=IDLE, pair=0, timer=0. All outputs are 0; sel/bank outputs are 0; fuzzier_sel is 1.
- States: IDLE, LAUNCH, WAIT_ACK, RUN, SEND, WAIT_TX_ACK, WAIT_TX, NEXT, ERROR.
- IDLE:
  - start=1 → LAUNCH; pair←0; error←0.
  - start is ignored in every other state.
- LAUNCH: dog_start=1 for exactly this cycle; timer←0 → WAIT_ACK.
- WAIT_ACK:
  - dog_busy=1 → RUN.
  - Otherwise timer increments; timer==ACK_TIMEOUT-1 with dog_busy=0 → ERROR.
  - dog_busy already high in the LAUNCH cycle counts as an acknowledgement on the first WAIT_ACK cycle.
- RUN:
  - out_we_en=1.
  - dog_busy=0 → SEND if SEND_EACH=1, else NEXT.
  - No timeout applies: `dog` run length is data-independent (DIMENSION² addresses plus pipeline).
- SEND: tx_start=1 for exactly this cycle; timer←0 → WAIT_TX_ACK.
- WAIT_TX_ACK:
  - tx_busy=1 → WAIT_TX.
  - Timeout rule is identical to WAIT_ACK → ERROR.
- WAIT_TX: tx_busy=0 → NEXT.
- NEXT:
  - pair==NUM_SCALES-2 → done=1 this cycle → IDLE.
  - Otherwise pair←pair+1 → LAUNCH.
- ERROR:
  - error=1, busy=1, no pulses issued.
  - Held until rst_in. start is ignored.
  - error clears only on reset or on the next accepted start.
- Selects are registered from pair and stable from LAUNCH through NEXT of that pair. They change only on the NEXT→LAUNCH transition, so `dog` BRAM read latency is never crossed by a select change.
- dog_start and tx_start are never high in the same cycle. Each is issued at most once per pair.
- Latency:
  - start → dog_start: 1 cycle (IDLE→LAUNCH registered; dog_start high in the LAUNCH cycle).
  - final falling edge of busy/tx_busy → done: 1 cycle.
- Timer width is $clog2(ACK_TIMEOUT)+1. Timer saturates and never wraps.

Test Plan:
- NUM_SCALES=3, SEND_EACH=0; start pulse; dog model raises busy 2 cycles after dog_start and holds it 20 cycles.
  → two dog_start pulses with (sharper_sel,fuzzier_sel,out_bank) = (0,1,0) then (1,2,1); no tx_start; done pulses once; busy falls with done.
- Same config, SEND_EACH=1; tx model busy 10 cycles after tx_start.
  → order is dog_start, tx_start(bank0), dog_start, tx_start(bank1), done.
  → out_we_en is high only while dog_busy is high.
- ACK_TIMEOUT=8; dog model never raises busy.
  → error=1 exactly 8 cycles after the WAIT_ACK entry; no further pulses; start ignored; rst_in clears error to 0 and state to IDLE.
- Reset asserted mid-RUN of pair 1.
  → all outputs 0 immediately (asynchronous, same cycle); fuzzier_sel=1; a new start restarts at pair 0.
- start pulsed again during RUN, and dog_busy already high at LAUNCH.
  → second start ignored (one done only); immediate acknowledgement advances to RUN the next cycle.
- NUM_SCALES=2 (single pair), SEND_EACH=1.
  → exactly one dog_start, one tx_start, one done; pair never exceeds 0.
